// File: rtl/csa_triplet_loader.sv
// rtl/csa_triplet_loader.sv - groups a 4-bit operand stream into x/y/z triplets for a 3-operand CSA
//
// Ports:
//   clk, rst                  single clock, synchronous active-high reset
//   in_data/in_valid/in_last  upstream operand stream; in_ready is high while filling
//   x, y, z                   operand triplet (first accepted word of a group on x)
//   out_valid/out_ready       downstream handshake; triplet held stable until taken
//   out_count                 number of real operands in the triplet (1..3)
//   out_last                  triplet closes a stream
// Unused slots of a short final group carry PAD.
module csa_triplet_loader #(
    parameter logic [3:0] PAD = 4'h0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [3:0] x,
    output logic [3:0] y,
    output logic [3:0] z,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_count,
    output logic       out_last
);

    typedef enum logic [1:0] {
        FILL0 = 2'd0,
        FILL1 = 2'd1,
        FILL2 = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] s0;
    logic [3:0] s1;

    logic       accept;
    logic       load_s0;
    logic       load_s1;
    logic       emit;
    logic [3:0] emit_x;
    logic [3:0] emit_y;
    logic [3:0] emit_z;
    logic [1:0] emit_count;
    logic       emit_last;

    // No input is taken while a triplet is pending; the HOLD->FILL0 edge is
    // the bubble cycle paid per triplet.
    assign in_ready = (state != HOLD);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_next = state;
        load_s0    = 1'b0;
        load_s1    = 1'b0;
        emit       = 1'b0;
        emit_x     = s0;
        emit_y     = s1;
        emit_z     = in_data;
        emit_count = 2'd3;
        emit_last  = in_last;
        case (state)
            FILL0: begin
                if (accept) begin
                    if (in_last) begin
                        emit       = 1'b1;
                        emit_x     = in_data;
                        emit_y     = PAD;
                        emit_z     = PAD;
                        emit_count = 2'd1;
                        emit_last  = 1'b1;
                        state_next = HOLD;
                    end else begin
                        load_s0    = 1'b1;
                        state_next = FILL1;
                    end
                end
            end
            FILL1: begin
                if (accept) begin
                    if (in_last) begin
                        emit       = 1'b1;
                        emit_x     = s0;
                        emit_y     = in_data;
                        emit_z     = PAD;
                        emit_count = 2'd2;
                        emit_last  = 1'b1;
                        state_next = HOLD;
                    end else begin
                        load_s1    = 1'b1;
                        state_next = FILL2;
                    end
                end
            end
            FILL2: begin
                if (accept) begin
                    emit       = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next = FILL0;
                end
            end
            default: state_next = FILL0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL0;
            s0        <= 4'h0;
            s1        <= 4'h0;
            x         <= 4'h0;
            y         <= 4'h0;
            z         <= 4'h0;
            out_count <= 2'd0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state <= state_next;
            if (load_s0) begin
                s0 <= in_data;
            end
            if (load_s1) begin
                s1 <= in_data;
            end
            if (emit) begin
                x         <= emit_x;
                y         <= emit_y;
                z         <= emit_z;
                out_count <= emit_count;
                out_last  <= emit_last;
                out_valid <= 1'b1;
            end else if (state == HOLD && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_csa_triplet_loader.sv
// tb/tb_csa_triplet_loader.sv - self-checking bench for csa_triplet_loader
module tb_csa_triplet_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] in_data = 4'h0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b1;

    logic       in_ready, out_valid, out_last;
    logic [3:0] x, y, z;
    logic [1:0] out_count;

    logic       in_ready_a, out_valid_a, out_last_a;
    logic [3:0] x_a, y_a, z_a;
    logic [1:0] out_count_a;

    always #5 clk = ~clk;

    csa_triplet_loader #(.PAD(4'h0)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .x(x), .y(y), .z(z),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_count(out_count), .out_last(out_last)
    );

    csa_triplet_loader #(.PAD(4'hA)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready_a), .x(x_a), .y(y_a), .z(z_a),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_count(out_count_a), .out_last(out_last_a)
    );

    // Expected triplet for the PAD=0 instance; the PAD=A instance differs
    // only in slots beyond ecnt.
    typedef struct {
        logic [3:0] ex;
        logic [3:0] ey;
        logic [3:0] ez;
        logic [1:0] ecnt;
        logic       elast;
    } exp_t;

    typedef struct {
        int              n;
        logic            last;
        logic [2:0][3:0] w;
        exp_t            e;
    } vec_t;

    exp_t sbq[$];
    vec_t tbl[6];

    int   total_cnt = 0;
    int   pass_cnt  = 0;
    logic rand_ready = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endfunction

    function automatic void push(logic [3:0] ex, logic [3:0] ey, logic [3:0] ez,
                                 logic [1:0] ecnt, logic elast);
        exp_t e;
        e.ex = ex; e.ey = ey; e.ez = ez; e.ecnt = ecnt; e.elast = elast;
        sbq.push_back(e);
    endfunction

    task automatic monitor();
        exp_t       e;
        logic [3:0] ya, za;
        if (!rst && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                chk("unexpected_triplet", {17'd0, x, y, z, out_count, out_last}, 32'd0);
            end else begin
                e  = sbq.pop_front();
                ya = (e.ecnt < 2'd2) ? 4'hA : e.ey;
                za = (e.ecnt < 2'd3) ? 4'hA : e.ez;
                chk("triplet_pad0", {17'd0, x, y, z, out_count, out_last},
                    {17'd0, e.ex, e.ey, e.ez, e.ecnt, e.elast});
                chk("triplet_padA", {16'd0, out_valid_a, x_a, y_a, z_a, out_count_a, out_last_a},
                    {16'd0, 1'b1, e.ex, ya, za, e.ecnt, e.elast});
            end
        end
    endtask

    task automatic neg();
        @(negedge clk);
        monitor();
    endtask

    task automatic pos();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic cyc();
        neg();
        pos();
    endtask

    // Leaves in_valid asserted; returns the number of cycles spent waiting.
    task automatic send_word(input logic [3:0] d, input logic l, output int waits);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        waits    = 0;
        neg();
        while (!in_ready && waits < 50) begin
            pos();
            waits++;
            neg();
        end
        if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
        pos();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() > 0 && n < 300) begin
            cyc();
            n++;
        end
        chk("drain_empty", sbq.size(), 32'd0);
    endtask

    initial begin
        int w;

        tbl[0] = '{n: 3, last: 1'b0, w: {4'h7, 4'h5, 4'h3}, e: '{4'h3, 4'h5, 4'h7, 2'd3, 1'b0}};
        tbl[1] = '{n: 2, last: 1'b1, w: {4'h0, 4'h1, 4'hF}, e: '{4'hF, 4'h1, 4'h0, 2'd2, 1'b1}};
        tbl[2] = '{n: 1, last: 1'b1, w: {4'h0, 4'h0, 4'h9}, e: '{4'h9, 4'h0, 4'h0, 2'd1, 1'b1}};
        tbl[3] = '{n: 3, last: 1'b1, w: {4'h6, 4'h4, 4'h2}, e: '{4'h2, 4'h4, 4'h6, 2'd3, 1'b1}};
        tbl[4] = '{n: 3, last: 1'b0, w: {4'h8, 4'hF, 4'h0}, e: '{4'h0, 4'hF, 4'h8, 2'd3, 1'b0}};
        tbl[5] = '{n: 1, last: 1'b1, w: {4'h0, 4'h0, 4'hE}, e: '{4'hE, 4'h0, 4'h0, 2'd1, 1'b1}};

        // Reset state
        rst = 1'b1;
        repeat (3) cyc();
        neg();
        chk("reset_out", {16'd0, out_valid, x, y, z, out_count, out_last}, 32'd0);
        chk("reset_out_a", {16'd0, out_valid_a, x_a, y_a, z_a, out_count_a, out_last_a}, 32'd0);
        pos();
        rst = 1'b0;
        neg();
        chk("ready_after_reset", {31'd0, in_ready}, 32'd1);
        pos();

        // Full group followed by exactly one bubble cycle
        push(4'h3, 4'h5, 4'h7, 2'd3, 1'b0);
        send_word(4'h3, 1'b0, w);
        send_word(4'h5, 1'b0, w);
        send_word(4'h7, 1'b0, w);
        in_valid = 1'b0;
        neg();
        chk("bubble_ready_low", {30'd0, in_ready, out_valid}, 32'd1);
        pos();
        neg();
        chk("bubble_ready_back", {30'd0, in_ready, out_valid}, 32'd2);
        pos();
        drain();

        // Table-driven groups
        for (int i = 0; i < 6; i++) begin
            sbq.push_back(tbl[i].e);
            for (int k = 0; k < tbl[i].n; k++) begin
                send_word(tbl[i].w[k], (k == tbl[i].n - 1) ? tbl[i].last : 1'b0, w);
            end
            in_valid = 1'b0;
            in_last  = 1'b0;
            drain();
        end

        // Backpressure: triplet pending, next word held on the input
        out_ready = 1'b0;
        push(4'h2, 4'h4, 4'h6, 2'd3, 1'b0);
        send_word(4'h2, 1'b0, w);
        send_word(4'h4, 1'b0, w);
        send_word(4'h6, 1'b0, w);
        in_data = 4'h8;
        in_last = 1'b0;
        for (int c = 0; c < 5; c++) begin
            neg();
            chk("stall_hold", {15'd0, in_ready, out_valid, x, y, z, out_count, out_last},
                {15'd0, 1'b0, 1'b1, 4'h2, 4'h4, 4'h6, 2'd3, 1'b0});
            pos();
        end
        out_ready = 1'b1;
        push(4'h8, 4'h9, 4'h1, 2'd3, 1'b1);
        send_word(4'h8, 1'b0, w);
        chk("stall_accept_delay", w, 32'd1);
        send_word(4'h9, 1'b0, w);
        send_word(4'h1, 1'b1, w);
        in_valid = 1'b0;
        in_last  = 1'b0;
        drain();

        // Reset in the middle of a group discards the partial words
        send_word(4'h1, 1'b0, w);
        send_word(4'h2, 1'b0, w);
        in_valid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        neg();
        chk("midreset_state", {23'd0, in_ready, out_valid, x, out_count}, {23'd0, 1'b1, 1'b0, 4'h0, 2'd0});
        pos();
        push(4'h3, 4'h4, 4'h5, 2'd3, 1'b1);
        send_word(4'h3, 1'b0, w);
        chk("midreset_first_accept", w, 32'd0);
        send_word(4'h4, 1'b0, w);
        send_word(4'h5, 1'b1, w);
        in_valid = 1'b0;
        in_last  = 1'b0;
        drain();

        // Stream of seven with random out_ready
        rand_ready = 1'b1;
        push(4'h1, 4'h2, 4'h3, 2'd3, 1'b0);
        push(4'h4, 4'h5, 4'h6, 2'd3, 1'b0);
        push(4'h7, 4'h0, 4'h0, 2'd1, 1'b1);
        for (int k = 1; k <= 7; k++) begin
            send_word(4'(k), (k == 7) ? 1'b1 : 1'b0, w);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        drain();
        rand_ready = 1'b0;
        out_ready  = 1'b1;

        // Idle input must not produce anything
        repeat (5) cyc();
        neg();
        chk("idle_no_output", {31'd0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
